// File: rtl/string_frame_ctrl.sv
// Framing controller: splits a handshaked byte stream at TERM, checks each string
// against digit(op digit)* and emits one result record (verdict, length, operators, overflow) per string.
module string_frame_ctrl #(
  parameter logic [7:0] TERM    = 8'h0A,
  parameter int         MAX_LEN = 255,
  parameter int         LEN_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             live_ok,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ok,
  output logic [LEN_W-1:0] res_len,
  output logic [LEN_W-1:0] res_ops,
  output logic             res_too_long
);

  typedef enum logic [1:0] {START, DIG, OP, ERR} state_t;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] ops_q, ops_d;
  logic             too_long_q, too_long_d;
  logic             live_ok_q, live_ok_d;
  logic             res_valid_q, res_valid_d;
  logic             res_ok_q, res_ok_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic [LEN_W-1:0] res_ops_q, res_ops_d;
  logic             res_too_long_q, res_too_long_d;

  logic accept, is_term, is_digit, char_accept, term_accept;

  assign in_ready    = !res_valid_q || res_ready;
  assign accept      = in_valid && in_ready;
  assign is_term     = (in_data == TERM);
  assign is_digit    = (in_data >= 8'h30) && (in_data <= 8'h39);
  // flush drops whatever byte happens to be accepted alongside it
  assign char_accept = accept && !is_term && !flush;
  assign term_accept = accept && is_term && !flush;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ops_d      = ops_q;
    too_long_d = too_long_q;
    live_ok_d  = live_ok_q;

    if (flush || term_accept) begin
      state_d    = START;
      len_d      = '0;
      ops_d      = '0;
      too_long_d = 1'b0;
      live_ok_d  = 1'b0;
    end else if (char_accept) begin
      unique case (state_q)
        START:   state_d = is_digit ? DIG : ERR;
        DIG:     state_d = is_digit ? ERR : OP;
        OP:      state_d = is_digit ? DIG : ERR;
        default: state_d = ERR;
      endcase
      if (len_q == MAX_CNT) too_long_d = 1'b1;
      else                  len_d      = len_q + 1'b1;
      if (!is_digit && ops_q != MAX_CNT) ops_d = ops_q + 1'b1;
      live_ok_d = (state_d == DIG);
    end
  end

  // Result register: a new terminator reloads it even on the edge the old record is consumed
  always_comb begin
    res_valid_d    = res_valid_q;
    res_ok_d       = res_ok_q;
    res_len_d      = res_len_q;
    res_ops_d      = res_ops_q;
    res_too_long_d = res_too_long_q;

    if (term_accept) begin
      res_valid_d    = 1'b1;
      res_ok_d       = (state_q == DIG) && !too_long_q;
      res_len_d      = len_q;
      res_ops_d      = ops_q;
      res_too_long_d = too_long_q;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q        <= START;
      len_q          <= '0;
      ops_q          <= '0;
      too_long_q     <= 1'b0;
      live_ok_q      <= 1'b0;
      res_valid_q    <= 1'b0;
      res_ok_q       <= 1'b0;
      res_len_q      <= '0;
      res_ops_q      <= '0;
      res_too_long_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      ops_q          <= ops_d;
      too_long_q     <= too_long_d;
      live_ok_q      <= live_ok_d;
      res_valid_q    <= res_valid_d;
      res_ok_q       <= res_ok_d;
      res_len_q      <= res_len_d;
      res_ops_q      <= res_ops_d;
      res_too_long_q <= res_too_long_d;
    end
  end

  assign live_ok      = live_ok_q;
  assign res_valid    = res_valid_q;
  assign res_ok       = res_ok_q;
  assign res_len      = res_len_q;
  assign res_ops      = res_ops_q;
  assign res_too_long = res_too_long_q;

endmodule
